axis_frame_receiver: RTL and testbench
======================================

AXIS_FRAME_RECEIVER -- requirements
Module: axis_frame_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, stream data width in bits (multiple of 8, at least 16).
REQ-002 SHALL have parameter MAX_BEATS, default 16, frame buffer depth in beats (power of 2, at least 2).
REQ-003 SHALL derive localparams: BW = WIDTH/8; AW = clog2(MAX_BEATS); LW = clog2(MAX_BEATS*BW+1).
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: t_data  in  WIDTH  stream payload.
REQ-007 Port: t_valid  in  1  beat valid.
REQ-008 Port: t_last  in  1  final beat of frame.
REQ-009 Port: byte_enable  in  BW  valid bytes of beat; bit i covers t_data[8i+7:8i].
REQ-010 Port: t_ready  out  1  receiver can accept a beat.
REQ-011 Port: frame_valid  out  1  completed-frame descriptor available.
REQ-012 Port: frame_ready  in  1  consumer releases descriptor and buffer.
REQ-013 Port: frame_len  out  LW  frame byte count.
REQ-014 Port: frame_beats  out  AW+1  frame beat count.
REQ-015 Port: frame_err  out  1  frame malformed or oversize.
REQ-016 Port: rd_addr  in  AW  buffer beat index.
REQ-017 Port: rd_data  out  WIDTH  buffer word at rd_addr, registered.

Function
REQ-018 Beat accepted SHALL mean the cycle where t_valid and t_ready are both 1; no other cycle changes state from the stream.
REQ-019 FSM states SHALL be IDLE, RECV, DROP, DONE.
REQ-020 t_ready SHALL be a registered output: 1 in IDLE, RECV and DROP; 0 in DONE.
REQ-021 IDLE:
- Accepted beat is written to buffer[0]; beat count becomes 1.
- With t_last=1 -> DONE; otherwise -> RECV.
REQ-022 RECV:
- Accepted beat is written at the current beat count, and the count increments.
- t_last=1 -> DONE.
- If an accepted beat would be beat MAX_BEATS+1 -> DROP; that beat is not written.
REQ-023 DROP:
- Accepted beats are discarded.
- Accepted beat with t_last=1 -> DONE, with frame_err=1, frame_len=0, frame_beats=0.
REQ-024 DONE: frame_valid=1; on frame_valid and frame_ready -> IDLE.
- Next cycle: frame_valid=0 and t_ready=1.
REQ-025 frame_valid SHALL rise on the cycle after the t_last beat is accepted (1-cycle latency).
- frame_len, frame_beats and frame_err are stable while frame_valid=1.
REQ-026 frame_len SHALL equal (frame_beats-1)*BW plus the popcount of the last beat's byte_enable.
REQ-027 frame_err SHALL be set (frame stays stored, len/beats reported as computed) when either condition holds:
- A non-last beat has byte_enable not all-ones.
- The last beat has byte_enable zero or not low-contiguous (legal: 0001, 0011, 0111, 1111 for BW=4).
REQ-028 A frame of exactly MAX_BEATS beats SHALL be accepted without error.
REQ-029 Buffer contents SHALL not change while in DONE.
REQ-030 rd_data SHALL return buffer[rd_addr] one cycle after rd_addr is presented.
- Contents beyond frame_beats are don't-care.
REQ-031 t_data and byte_enable SHALL be ignored when t_valid=0.
REQ-032 A frame_ready=1 outside DONE SHALL have no effect.

Reset
REQ-033 rst_n=0 SHALL immediately force the following, regardless of in-progress frame or pending descriptor:
- FSM state to IDLE.
- t_ready, frame_valid, frame_err and rd_data to 0.
- frame_len and frame_beats to 0.
- Beat count to 0.
REQ-034 t_ready SHALL first assert on the first clk edge after rst_n deasserts.
REQ-035 Buffer memory need not be reset.

Verification
REQ-036 Single beat:
- Stimulus: t_data=0xDEADBEEF, byte_enable=4'b0011, t_last=1.
- Response: next cycle frame_valid=1, frame_len=2, frame_beats=1, frame_err=0, t_ready=0; rd_addr=0 gives 0xDEADBEEF after 1 cycle.
REQ-037 Backpressure and release:
- Stimulus: 3-beat frame with full byte_enable, then a second frame offered; frame_ready held 0 for 5 cycles, then pulsed.
- Response: t_ready=0 and the descriptor is held (len=12) for the 5 cycles; t_ready=1 the cycle after the handshake; the second frame is received intact.
REQ-038 Oversize:
- Stimulus: 17-beat frame with MAX_BEATS=16.
- Response: all 17 beats accepted; frame_err=1, frame_len=0, frame_beats=0.
- Boundary: a 16-beat frame gives frame_err=0, frame_len=64.
REQ-039 Malformed byte_enable:
- Stimulus: last beat byte_enable=4'b0101; separately, a middle beat with 4'b0111.
- Response: frame_err=1 in both cases.
REQ-040 Reset mid-operation:
- Stimulus: rst_n=0 after beat 2 of 4, and separately during DONE.
- Response: frame_valid=0 and t_ready=0 immediately; after release, a new 1-beat frame gives frame_beats=1.
REQ-041 Valid gaps:
- Stimulus: t_valid toggled 1,0,0,1,1 with t_last on the final beat.
- Response: frame_beats=3; idle cycles leave the count unchanged.

Source files
------------

// File: rtl/axis_frame_receiver.sv
// AXI-stream frame receiver: buffers one frame of up to MAX_BEATS beats
// and presents a length/beat/error descriptor until the consumer releases it.
module axis_frame_receiver #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [WIDTH-1:0]                        t_data,
  input  logic                                    t_valid,
  input  logic                                    t_last,
  input  logic [WIDTH/8-1:0]                      byte_enable,
  output logic                                    t_ready,
  output logic                                    frame_valid,
  input  logic                                    frame_ready,
  output logic [$clog2(MAX_BEATS*(WIDTH/8)+1)-1:0] frame_len,
  output logic [$clog2(MAX_BEATS):0]              frame_beats,
  output logic                                    frame_err,
  input  logic [$clog2(MAX_BEATS)-1:0]            rd_addr,
  output logic [WIDTH-1:0]                        rd_data
);

  localparam int BW = WIDTH / 8;
  localparam int AW = $clog2(MAX_BEATS);
  localparam int LW = $clog2(MAX_BEATS * BW + 1);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_t_ready;
  logic [AW:0]      r_cnt;
  logic             r_err;
  logic [LW-1:0]    r_len;
  logic [AW:0]      r_beats;
  logic             r_ferr;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_mem [MAX_BEATS];

  logic             w_acc;
  logic             w_be_full;
  logic             w_last_ok;
  logic [BW-1:0]    w_be_inc;
  logic [LW-1:0]    w_pop;
  logic [LW-1:0]    w_idx_bytes;
  logic             w_wr;
  logic [AW-1:0]    w_waddr;
  logic [AW:0]      w_cnt_nxt;
  logic             w_err_nxt;
  logic             w_load;
  logic [LW-1:0]    w_len_nxt;
  logic [AW:0]      w_beats_nxt;
  logic             w_ferr_nxt;

  function automatic logic [LW-1:0] f_pop(input logic [BW-1:0] be);
    logic [LW-1:0] s;
    s = '0;
    for (int i = 0; i < BW; i++) begin
      s = s + LW'(be[i]);
    end
    return s;
  endfunction

  assign w_acc       = t_valid & r_t_ready;
  assign w_be_full   = &byte_enable;
  assign w_be_inc    = byte_enable + BW'(1);
  // Low-contiguous mask: nonzero and adding one clears every set bit.
  assign w_last_ok   = (|byte_enable) &&
                       ((byte_enable & w_be_inc) == '0);
  assign w_pop       = f_pop(byte_enable);
  assign w_idx_bytes = LW'(r_cnt) * LW'(BW);

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_waddr     = r_cnt[AW-1:0];
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_len_nxt   = '0;
    w_beats_nxt = '0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_wr      = 1'b1;
          w_waddr   = '0;
          w_cnt_nxt = (AW+1)'(1);
          if (t_last) begin
            w_load      = 1'b1;
            w_len_nxt   = w_pop;
            w_beats_nxt = (AW+1)'(1);
            w_ferr_nxt  = ~w_last_ok;
            w_state_nxt = S_DONE;
          end else begin
            w_err_nxt   = ~w_be_full;
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_acc) begin
          if (r_cnt == CNT_FULL) begin
            // Buffer is full: this beat is dropped and the frame flagged.
            if (t_last) begin
              w_load      = 1'b1;
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_DROP;
            end
          end else begin
            w_wr      = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (t_last) begin
              w_load      = 1'b1;
              w_len_nxt   = w_idx_bytes + w_pop;
              w_beats_nxt = r_cnt + 1'b1;
              w_ferr_nxt  = r_err | ~w_last_ok;
              w_state_nxt = S_DONE;
            end else begin
              w_err_nxt = r_err | ~w_be_full;
            end
          end
        end
      end
      S_DROP: begin
        if (w_acc && t_last) begin
          w_load      = 1'b1;
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (frame_ready) begin
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_t_ready <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_len     <= '0;
      r_beats   <= '0;
      r_ferr    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_t_ready <= (w_state_nxt != S_DONE);
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
      r_rd_data <= r_mem[rd_addr];
      if (w_load) begin
        r_len   <= w_len_nxt;
        r_beats <= w_beats_nxt;
        r_ferr  <= w_ferr_nxt;
      end
    end
  end

  // Frame storage carries no reset; only written beats are ever read back.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_waddr] <= t_data;
    end
  end

  assign t_ready     = r_t_ready;
  assign frame_valid = (r_state == S_DONE);
  assign frame_len   = r_len;
  assign frame_beats = r_beats;
  assign frame_err   = r_ferr;
  assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_axis_frame_receiver.sv
// Directed self-checking bench for axis_frame_receiver
// (WIDTH=32, MAX_BEATS=16).
module tb_axis_frame_receiver;

  logic        clk;
  logic        rst_n;
  logic [31:0] t_data;
  logic        t_valid;
  logic        t_last;
  logic [3:0]  byte_enable;
  logic        t_ready;
  logic        frame_valid;
  logic        frame_ready;
  logic [6:0]  frame_len;
  logic [4:0]  frame_beats;
  logic        frame_err;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  int checks   = 0;
  int failures = 0;

  axis_frame_receiver #(.WIDTH(32), .MAX_BEATS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .t_data     (t_data),
    .t_valid    (t_valid),
    .t_last     (t_last),
    .byte_enable(byte_enable),
    .t_ready    (t_ready),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_len  (frame_len),
    .frame_beats(frame_beats),
    .frame_err  (frame_err),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns on a negedge; holds the beat until it is accepted.
  task automatic send(input logic [31:0] d, input logic [3:0] be,
                      input logic last);
    int n;
    n = 0;
    t_valid = 1'b1;
    t_data = d;
    byte_enable = be;
    t_last = last;
    while (!t_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    t_valid = 1'b0;
    t_last = 1'b0;
  endtask

  task automatic desc(input string tag, input logic [31:0] len,
                      input logic [31:0] beats, input logic err);
    chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
    chk({tag, "_len"}, 32'(frame_len), len);
    chk({tag, "_beats"}, 32'(frame_beats), beats);
    chk({tag, "_err"}, 32'(frame_err), 32'(err));
  endtask

  task automatic rel();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("release_valid", 32'(frame_valid), 32'd0);
    chk("release_ready", 32'(t_ready), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    logic [31:0] exp2 [3];
    exp2[0] = 32'hAAAA0001;
    exp2[1] = 32'hAAAA0002;
    exp2[2] = 32'hAAAA0003;
    rst_n = 1'b0;
    t_data = '0;
    t_valid = 1'b0;
    t_last = 1'b0;
    byte_enable = '0;
    frame_ready = 1'b0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(t_ready), 32'd0);
    chk("rst_fvalid", 32'(frame_valid), 32'd0);
    chk("rst_len", 32'(frame_len), 32'd0);
    chk("rst_beats", 32'(frame_beats), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_pre", 32'(t_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_post", 32'(t_ready), 32'd1);

    // Single beat
    send(32'hDEADBEEF, 4'b0011, 1'b1);
    desc("single", 2, 1, 1'b0);
    chk("single_tready", 32'(t_ready), 32'd0);
    rd("single_rd", 4'd0, 32'hDEADBEEF);
    rel();

    // Backpressure: second frame offered while descriptor held
    send(32'h11111111, 4'hF, 1'b0);
    send(32'h22222222, 4'hF, 1'b0);
    send(32'h33333333, 4'hF, 1'b1);
    t_valid = 1'b1;
    t_data = exp2[0];
    byte_enable = 4'hF;
    t_last = 1'b0;
    rd_addr = 4'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_tready", 32'(t_ready), 32'd0);
      chk("bp_fvalid", 32'(frame_valid), 32'd1);
      chk("bp_len", 32'(frame_len), 32'd12);
      @(negedge clk);
      chk("bp_hold_rd", rd_data, 32'h33333333);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("bp_rel_ready", 32'(t_ready), 32'd1);
    chk("bp_rel_fvalid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    send(exp2[1], 4'hF, 1'b0);
    send(exp2[2], 4'b0001, 1'b1);
    desc("second", 9, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd("second_rd", 4'(i), exp2[i]);
    end
    rel();

    // Oversize: 17 beats
    for (int i = 0; i < 17; i++) begin
      send(32'h100 + 32'(i), 4'hF, 1'(i == 16));
    end
    desc("over17", 0, 0, 1'b1);
    rel();

    // Boundary: exactly 16 beats
    for (int i = 0; i < 16; i++) begin
      send(32'h200 + 32'(i), 4'hF, 1'(i == 15));
    end
    desc("full16", 64, 16, 1'b0);
    rd("full16_rd15", 4'd15, 32'h20F);
    rd("full16_rd0", 4'd0, 32'h200);
    rel();

    // Malformed byte enables
    send(32'h1, 4'hF, 1'b0);
    send(32'h2, 4'b0101, 1'b1);
    desc("bad_last", 6, 2, 1'b1);
    rel();
    send(32'h1, 4'hF, 1'b0);
    send(32'h2, 4'b0111, 1'b0);
    send(32'h3, 4'hF, 1'b1);
    desc("bad_mid", 12, 3, 1'b1);
    rel();
    send(32'h1, 4'hF, 1'b0);
    send(32'h2, 4'b0000, 1'b1);
    desc("zero_last", 4, 2, 1'b1);
    rel();

    // Valid gaps with garbage data and stray frame_ready outside DONE
    send(32'hC0DE0001, 4'hF, 1'b0);
    t_data = 32'hFFFFFFFF;
    byte_enable = 4'b0101;
    t_last = 1'b1;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    frame_ready = 1'b0;
    t_last = 1'b0;
    send(32'hC0DE0002, 4'hF, 1'b0);
    send(32'hC0DE0003, 4'hF, 1'b1);
    desc("gaps", 12, 3, 1'b0);
    rd("gaps_rd1", 4'd1, 32'hC0DE0002);
    rel();

    // Reset mid-frame
    send(32'h5, 4'hF, 1'b0);
    send(32'h6, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_fvalid", 32'(frame_valid), 32'd0);
    chk("rstmid_ready", 32'(t_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h7, 4'b0001, 1'b1);
    desc("after_rstmid", 1, 1, 1'b0);
    rel();

    // Reset during DONE
    send(32'h8, 4'hF, 1'b1);
    chk("done_fvalid", 32'(frame_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstdone_fvalid", 32'(frame_valid), 32'd0);
    chk("rstdone_ready", 32'(t_ready), 32'd0);
    chk("rstdone_len", 32'(frame_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h9, 4'hF, 1'b1);
    desc("after_rstdone", 4, 1, 1'b0);
    rel();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
